rs232_fifo_slave: RTL and testbench

// - Avalon-MM slave bridging the CPU to the RS-232 byte channel, with separate parametrised TX/RX FIFOs.
// - Replaces the single-register, single-byte slave: the CPU can queue bursts and poll fill levels.
// - Sits between the Avalon interconnect and the RS-232 serialiser/deserialiser; byte side uses the rdy/ack handshake.

---
 rtl/rs232_fifo_slave_if.sv | 29 ++
 rtl/rs232_fifo_slave.sv | 182 ++++++++++++++++++
 tb/tb_rs232_fifo_slave.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/rs232_fifo_slave_if.sv
// Avalon-MM bus plus RS-232 byte-channel rdy/ack handshake for rs232_fifo_slave.
// The slave modport is the bridge's view; master is the CPU/serialiser side.
interface rs232_fifo_slave_if #(
  parameter int DATA_W = 8
) ();
  logic [4:0]        avm_address;
  logic              avm_actually_read;
  logic [31:0]       avm_readdata;
  logic              avm_actually_write;
  logic [31:0]       avm_writedata;
  logic              to232_rdy;
  logic              to232_ack;
  logic [DATA_W-1:0] to232_dat;
  logic              from232_rdy;
  logic              from232_ack;
  logic [DATA_W-1:0] from232_dat;

  modport slave (
    input  avm_address, avm_actually_read, avm_actually_write, avm_writedata,
    input  to232_ack, from232_rdy, from232_dat,
    output avm_readdata, to232_rdy, to232_dat, from232_ack
  );

  modport master (
    output avm_address, avm_actually_read, avm_actually_write, avm_writedata,
    output to232_ack, from232_rdy, from232_dat,
    input  avm_readdata, to232_rdy, to232_dat, from232_ack
  );
endinterface

// File: rtl/rs232_fifo_slave.sv
// Avalon-MM slave with separate TX/RX FIFOs toward an RS-232 rdy/ack byte channel.
// Define RS232_FIFO_IRQ_EN to add the irq output and the IRQEN register at address 16.
module rs232_fifo_slave #(
  parameter int DATA_W   = 8,
  parameter int TX_DEPTH = 16,
  parameter int RX_DEPTH = 16
) (
  input  logic avm_clk,
  input  logic avm_rst_n,
`ifdef RS232_FIFO_IRQ_EN
  output logic irq,
`endif
  rs232_fifo_slave_if.slave bus
);

  localparam int TX_AW = $clog2(TX_DEPTH);
  localparam int RX_AW = $clog2(RX_DEPTH);
  localparam int TX_CW = TX_AW + 1;
  localparam int RX_CW = RX_AW + 1;

  localparam logic [4:0] ADDR_RXDATA = 5'd0;
  localparam logic [4:0] ADDR_TXDATA = 5'd4;
  localparam logic [4:0] ADDR_STATUS = 5'd8;
  localparam logic [4:0] ADDR_CTRL   = 5'd12;
`ifdef RS232_FIFO_IRQ_EN
  localparam logic [4:0] ADDR_IRQEN  = 5'd16;
`endif

  logic [DATA_W-1:0] tx_mem_q [TX_DEPTH];
  logic [DATA_W-1:0] rx_mem_q [RX_DEPTH];

  logic [TX_AW-1:0] tx_wr_ptr_q, tx_wr_ptr_d, tx_rd_ptr_q, tx_rd_ptr_d;
  logic [RX_AW-1:0] rx_wr_ptr_q, rx_wr_ptr_d, rx_rd_ptr_q, rx_rd_ptr_d;
  logic [TX_CW-1:0] tx_count_q, tx_count_d;
  logic [RX_CW-1:0] rx_count_q, rx_count_d;
  logic             txovf_q, txovf_d;
  logic             rx_ack_q, rx_ack_d;

  logic tx_full, tx_empty, rx_full, rx_empty;
  logic rd_rx, wr_tx, wr_ctrl;
  logic tx_push, tx_pop, tx_ovf_evt, rx_push, rx_pop;
  logic flush_tx, flush_rx, clr_ovf;
  logic [DATA_W-1:0] rx_head;
  logic [31:0] status;
  logic [31:0] rdata;
  logic unused_wdata_bits;

  assign unused_wdata_bits = ^bus.avm_writedata;

  assign tx_full  = (tx_count_q == TX_CW'(TX_DEPTH));
  assign tx_empty = (tx_count_q == '0);
  assign rx_full  = (rx_count_q == RX_CW'(RX_DEPTH));
  assign rx_empty = (rx_count_q == '0);

  assign rd_rx   = bus.avm_actually_read  && (bus.avm_address == ADDR_RXDATA);
  assign wr_tx   = bus.avm_actually_write && (bus.avm_address == ADDR_TXDATA);
  assign wr_ctrl = bus.avm_actually_write && (bus.avm_address == ADDR_CTRL);

  assign clr_ovf  = wr_ctrl && bus.avm_writedata[0];
  assign flush_rx = wr_ctrl && bus.avm_writedata[1];
  assign flush_tx = wr_ctrl && bus.avm_writedata[2];

  // Full/empty come from pre-edge state, so a write on a full FIFO is lost even if a pop coincides.
  assign tx_pop     = !tx_empty && bus.to232_ack;
  assign tx_push    = wr_tx && !tx_full;
  assign tx_ovf_evt = wr_tx && tx_full;
  assign rx_push    = bus.from232_rdy && rx_ack_q;
  assign rx_pop     = rd_rx && !rx_empty;

  always_comb begin
    tx_wr_ptr_d = tx_wr_ptr_q;
    tx_rd_ptr_d = tx_rd_ptr_q;
    tx_count_d  = tx_count_q;
    if (flush_tx) begin
      tx_wr_ptr_d = '0;
      tx_rd_ptr_d = '0;
      tx_count_d  = '0;
    end else begin
      if (tx_push) tx_wr_ptr_d = tx_wr_ptr_q + TX_AW'(1);
      if (tx_pop)  tx_rd_ptr_d = tx_rd_ptr_q + TX_AW'(1);
      case ({tx_push, tx_pop})
        2'b10:   tx_count_d = tx_count_q + TX_CW'(1);
        2'b01:   tx_count_d = tx_count_q - TX_CW'(1);
        default: tx_count_d = tx_count_q;
      endcase
    end
  end

  always_comb begin
    rx_wr_ptr_d = rx_wr_ptr_q;
    rx_rd_ptr_d = rx_rd_ptr_q;
    rx_count_d  = rx_count_q;
    if (flush_rx) begin
      rx_wr_ptr_d = '0;
      rx_rd_ptr_d = '0;
      rx_count_d  = '0;
    end else begin
      if (rx_push) rx_wr_ptr_d = rx_wr_ptr_q + RX_AW'(1);
      if (rx_pop)  rx_rd_ptr_d = rx_rd_ptr_q + RX_AW'(1);
      case ({rx_push, rx_pop})
        2'b10:   rx_count_d = rx_count_q + RX_CW'(1);
        2'b01:   rx_count_d = rx_count_q - RX_CW'(1);
        default: rx_count_d = rx_count_q;
      endcase
    end
  end

  assign txovf_d  = (txovf_q && !clr_ovf) || tx_ovf_evt;
  // ack is registered from the next count so it never depends on the peer's rdy.
  assign rx_ack_d = (rx_count_d != RX_CW'(RX_DEPTH));

  always_ff @(posedge avm_clk or negedge avm_rst_n) begin
    if (!avm_rst_n) begin
      tx_wr_ptr_q <= '0;
      tx_rd_ptr_q <= '0;
      tx_count_q  <= '0;
      rx_wr_ptr_q <= '0;
      rx_rd_ptr_q <= '0;
      rx_count_q  <= '0;
      txovf_q     <= 1'b0;
      rx_ack_q    <= 1'b0;
    end else begin
      tx_wr_ptr_q <= tx_wr_ptr_d;
      tx_rd_ptr_q <= tx_rd_ptr_d;
      tx_count_q  <= tx_count_d;
      rx_wr_ptr_q <= rx_wr_ptr_d;
      rx_rd_ptr_q <= rx_rd_ptr_d;
      rx_count_q  <= rx_count_d;
      txovf_q     <= txovf_d;
      rx_ack_q    <= rx_ack_d;
    end
  end

  // Storage carries no reset; validity is tracked entirely by the pointers and counts.
  always_ff @(posedge avm_clk) begin
    if (tx_push) tx_mem_q[tx_wr_ptr_q] <= bus.avm_writedata[DATA_W-1:0];
    if (rx_push) rx_mem_q[rx_wr_ptr_q] <= bus.from232_dat;
  end

  assign rx_head       = rx_mem_q[rx_rd_ptr_q];
  assign bus.to232_rdy   = !tx_empty;
  assign bus.to232_dat   = tx_empty ? '0 : tx_mem_q[tx_rd_ptr_q];
  assign bus.from232_ack = rx_ack_q;

  assign status = {8'd0, 8'(tx_count_q), 8'(rx_count_q),
                   !rx_empty, !tx_full, txovf_q, 5'd0};

`ifdef RS232_FIFO_IRQ_EN
  logic [2:0] irqen_q;
  logic       irq_q;

  always_ff @(posedge avm_clk or negedge avm_rst_n) begin
    if (!avm_rst_n) begin
      irqen_q <= 3'd0;
      irq_q   <= 1'b0;
    end else begin
      if (bus.avm_actually_write && (bus.avm_address == ADDR_IRQEN))
        irqen_q <= bus.avm_writedata[2:0];
      irq_q <= |(irqen_q & {txovf_q, tx_empty, !rx_empty});
    end
  end

  assign irq = irq_q;
`endif

  always_comb begin
    rdata = 32'd0;
    if (bus.avm_actually_read) begin
      case (bus.avm_address)
        ADDR_RXDATA: if (!rx_empty) rdata = 32'(rx_head);
        ADDR_STATUS: rdata = status;
`ifdef RS232_FIFO_IRQ_EN
        ADDR_IRQEN:  rdata = 32'(irqen_q);
`endif
        default:     rdata = 32'd0;
      endcase
    end
  end

  assign bus.avm_readdata = rdata;

endmodule

// File: tb/tb_rs232_fifo_slave.sv
// Randomised scoreboard bench for rs232_fifo_slave against a queue-based reference model.
module tb_rs232_fifo_slave;
  localparam int DW  = 8;
  localparam int TXD = 16;
  localparam int RXD = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
`ifdef RS232_FIFO_IRQ_EN
  logic irq;
`endif

  rs232_fifo_slave_if #(.DATA_W(DW)) bus_if ();

  rs232_fifo_slave #(.DATA_W(DW), .TX_DEPTH(TXD), .RX_DEPTH(RXD)) dut (
    .avm_clk   (clk),
    .avm_rst_n (rst_n),
`ifdef RS232_FIFO_IRQ_EN
    .irq       (irq),
`endif
    .bus       (bus_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned       cyc;
    bit                rd;
    bit                wr;
    logic [4:0]        addr;
    logic [31:0]       wdata;
    logic [31:0]       rdata;
    bit                tx_rdy;
    logic [DW-1:0]     tx_dat;
    bit                rx_ack;
    bit                irq;
    bit                txa;
    bit                rxr;
    logic [DW-1:0]     rxd;
  } exp_t;

  exp_t exp_q[$];
  int compared = 0;
  int mismatched = 0;

  // Reference model: plain byte queues plus a few flags.
  logic [DW-1:0] m_tx[$];
  logic [DW-1:0] m_rx[$];
  bit            m_ovf;
  bit            m_armed;
  bit [2:0]      m_irqen;
  bit            m_irq;
  int unsigned   cyc_n = 0;

  task automatic check(input string name, input int unsigned cyc,
                       input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s cyc=%0d actual=0x%08h required=0x%08h", name, cyc, act, exp);
    end
  endtask

  task automatic drive_idle();
    bus_if.avm_actually_read  = 1'b0;
    bus_if.avm_actually_write = 1'b0;
    bus_if.avm_address        = 5'd0;
    bus_if.avm_writedata      = 32'd0;
    bus_if.to232_ack          = 1'b0;
    bus_if.from232_rdy        = 1'b0;
    bus_if.from232_dat        = '0;
  endtask

  task automatic cycle(input bit rd, input bit wr, input logic [4:0] addr,
                       input logic [31:0] wdata, input bit txa, input bit rxr,
                       input logic [DW-1:0] rxd);
    exp_t e;
    int   txn, rxn;
    bit   wr_ctrl;
    @(posedge clk);
    #1;
    bus_if.avm_actually_read  = rd;
    bus_if.avm_actually_write = wr;
    bus_if.avm_address        = addr;
    bus_if.avm_writedata      = wdata;
    bus_if.to232_ack          = txa;
    bus_if.from232_rdy        = rxr;
    bus_if.from232_dat        = rxd;

    txn = m_tx.size();
    rxn = m_rx.size();
    e.cyc = cyc_n;  cyc_n++;
    e.rd = rd;  e.wr = wr;  e.addr = addr;  e.wdata = wdata;
    e.txa = txa;  e.rxr = rxr;  e.rxd = rxd;
    e.tx_rdy = (txn != 0);
    e.tx_dat = (txn != 0) ? m_tx[0] : '0;
    e.rx_ack = m_armed && (rxn != RXD);
    e.irq    = m_irq;
    e.rdata  = 32'd0;
    if (rd) begin
      if (addr == 5'd0 && rxn != 0) e.rdata = 32'(m_rx[0]);
      else if (addr == 5'd8)
        e.rdata = {8'd0, 8'(txn), 8'(rxn), rxn != 0, txn != TXD, m_ovf, 5'd0};
`ifdef RS232_FIFO_IRQ_EN
      else if (addr == 5'd16) e.rdata = 32'(m_irqen);
`endif
    end
    exp_q.push_back(e);

    // Advance the model across the coming clock edge.
    m_irq   = |(m_irqen & {m_ovf, txn == 0, rxn != 0});
    wr_ctrl = wr && (addr == 5'd12);
    if (wr_ctrl && wdata[2]) m_tx.delete();
    else begin
      if (e.tx_rdy && txa) void'(m_tx.pop_front());
      if (wr && addr == 5'd4 && txn != TXD) m_tx.push_back(wdata[DW-1:0]);
    end
    m_ovf = (m_ovf && !(wr_ctrl && wdata[0])) || (wr && addr == 5'd4 && txn == TXD);
    if (wr_ctrl && wdata[1]) m_rx.delete();
    else begin
      if (rd && addr == 5'd0 && rxn != 0) void'(m_rx.pop_front());
      if (rxr && e.rx_ack) m_rx.push_back(rxd);
    end
`ifdef RS232_FIFO_IRQ_EN
    if (wr && addr == 5'd16) m_irqen = wdata[2:0];
`endif
    m_armed = 1'b1;
  endtask

  task automatic do_reset(input int hold);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_to232_rdy", cyc_n, 32'(bus_if.to232_rdy), 32'd0);
    check("rst_from232_ack", cyc_n, 32'(bus_if.from232_ack), 32'd0);
    check("rst_to232_dat", cyc_n, 32'(bus_if.to232_dat), 32'd0);
    drive_idle();
    m_tx.delete();
    m_rx.delete();
    m_ovf = 1'b0;  m_irqen = 3'd0;  m_irq = 1'b0;  m_armed = 1'b0;
    exp_q.delete();
    repeat (hold) @(posedge clk);
    @(negedge clk);
    #3;
    rst_n = 1'b1;
    #1;
    check("rel_from232_ack", cyc_n, 32'(bus_if.from232_ack), 32'd0);
    // The next cycle() waits on the first post-release edge, which arms ack.
    m_armed = 1'b1;
  endtask

  // Monitor: pops the expectation for each driven cycle mid-cycle.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("readdata", e.cyc, bus_if.avm_readdata, e.rdata);
        check("to232_rdy", e.cyc, 32'(bus_if.to232_rdy), 32'(e.tx_rdy));
        if (e.tx_rdy) check("to232_dat", e.cyc, 32'(bus_if.to232_dat), 32'(e.tx_dat));
        check("from232_ack", e.cyc, 32'(bus_if.from232_ack), 32'(e.rx_ack));
`ifdef RS232_FIFO_IRQ_EN
        check("irq", e.cyc, 32'(irq), 32'(e.irq));
`endif
        if (e.rd) $display("cyc=%0d rd addr=%0d data=0x%08h", e.cyc, e.addr, bus_if.avm_readdata);
        if (e.wr) $display("cyc=%0d wr addr=%0d data=0x%08h", e.cyc, e.addr, e.wdata);
        if (bus_if.to232_rdy && e.txa) $display("cyc=%0d tx byte=0x%02h", e.cyc, bus_if.to232_dat);
        if (bus_if.from232_ack && e.rxr) $display("cyc=%0d rx byte=0x%02h", e.cyc, e.rxd);
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic random_phase(input int n);
    int op, ph, tp, rp;
    bit rd, wr;
    logic [4:0] a;
    logic [31:0] wd;
    for (int i = 0; i < n; i++) begin
      op = $urandom_range(0, 99);
      ph = (i / 150) % 4;
      tp = (ph % 2 == 1) ? 20 : 80;
      rp = (ph >= 2) ? 80 : 25;
      rd = 1'b0;  wr = 1'b0;  a = 5'd0;  wd = $urandom;
      if (op < 25)      begin rd = 1'b1; a = 5'd0;  end
      else if (op < 40) begin rd = 1'b1; a = 5'd8;  end
      else if (op < 70) begin wr = 1'b1; a = 5'd4;  end
      else if (op < 72) begin wr = 1'b1; a = 5'd12; end
      else if (op < 78) begin rd = 1'b1; a = 5'($urandom_range(0, 31)); end
      else if (op < 84) begin wr = 1'b1; a = 5'($urandom_range(0, 31)); end
      cycle(rd, wr, a, wd, $urandom_range(0, 99) < tp, $urandom_range(0, 99) < rp,
            DW'($urandom));
    end
  endtask

  initial begin : stimulus
    drive_idle();
    do_reset(3);

    // Idle status after reset.
    cycle(1, 0, 5'd8, 0, 0, 0, 0);

    // Three bytes queued with ack low, then drained in order.
    for (int b = 'h41; b <= 'h43; b++) cycle(0, 1, 5'd4, 32'(b), 0, 0, 0);
    cycle(1, 0, 5'd8, 0, 0, 0, 0);
    repeat (3) cycle(0, 0, 5'd0, 0, 1, 0, 0);
    cycle(1, 0, 5'd8, 0, 0, 0, 0);

    // TX overflow: 16 fills plus a dropped 17th, then clear TXOVF.
    for (int i = 0; i < TXD; i++) cycle(0, 1, 5'd4, 32'(8'h10 + i), 0, 0, 0);
    cycle(0, 1, 5'd4, 32'h99, 0, 0, 0);
    cycle(1, 0, 5'd8, 0, 0, 0, 0);
    cycle(0, 1, 5'd12, 32'h1, 0, 0, 0);
    cycle(1, 0, 5'd8, 0, 0, 0, 0);
    repeat (TXD + 1) cycle(0, 0, 5'd0, 0, 1, 0, 0);

    // RX fill past full, then read with rdy held.
    for (int i = 0; i < RXD + 2; i++) cycle(0, 0, 5'd0, 0, 0, 1, DW'(8'h60 + i));
    cycle(1, 0, 5'd8, 0, 0, 0, 0);
    cycle(1, 0, 5'd0, 0, 0, 1, DW'(8'hA0));
    cycle(0, 0, 5'd0, 0, 0, 1, DW'(8'hA1));
    cycle(1, 0, 5'd8, 0, 0, 1, DW'(8'hA2));
    cycle(0, 1, 5'd12, 32'h2, 0, 0, 0);
    cycle(1, 0, 5'd8, 0, 0, 0, 0);

    // Simultaneous pop and push at RX count 5.
    for (int i = 0; i < 5; i++) cycle(0, 0, 5'd0, 0, 0, 1, DW'(8'hB0 + i));
    cycle(1, 0, 5'd0, 0, 0, 1, DW'(8'hB5));
    cycle(1, 0, 5'd8, 0, 0, 0, 0);
    repeat (6) cycle(1, 0, 5'd0, 0, 0, 0, 0);
    cycle(1, 0, 5'd8, 0, 0, 0, 0);

`ifdef RS232_FIFO_IRQ_EN
    cycle(0, 1, 5'd16, 32'h1, 0, 0, 0);
    cycle(0, 0, 5'd0, 0, 0, 1, DW'(8'hC0));
    repeat (2) cycle(0, 0, 5'd0, 0, 0, 0, 0);
    cycle(1, 0, 5'd0, 0, 0, 0, 0);
    repeat (2) cycle(0, 0, 5'd0, 0, 0, 0, 0);
    cycle(1, 0, 5'd16, 0, 0, 0, 0);
`endif

    random_phase(1500);

    // Reset in the middle of traffic.
    for (int i = 0; i < 4; i++) cycle(0, 1, 5'd4, 32'(8'hD0 + i), 0, 1, DW'(8'hE0 + i));
    cycle(0, 0, 5'd0, 0, 1, 1, DW'(8'hE7));
    do_reset(2);
    cycle(1, 0, 5'd8, 0, 0, 0, 0);

    random_phase(300);

    repeat (2) @(posedge clk);
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
